// File: rtl/conv_frame_ctrl_if.sv
// Pixel-ingest and window-issue handshake bundle of the convolution frame controller.
`default_nettype none

interface conv_frame_ctrl_if #(
    parameter int ADDR_W  = 11,
    parameter int COORD_W = 6
);
    logic               start;
    logic               pix_valid;
    logic               pix_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic               win_valid;
    logic               win_ready;
    logic [ADDR_W-1:0]  win_addr;
    logic [COORD_W-1:0] win_row;
    logic [COORD_W-1:0] win_col;
    logic               busy;
    logic               done;
    logic [15:0]        stall_cnt;

    modport master (
        input  start, pix_valid, win_ready,
        output pix_ready, wr_en, wr_addr, win_valid, win_addr, win_row, win_col,
               busy, done, stall_cnt
    );

    modport slave (
        output start, pix_valid, win_ready,
        input  pix_ready, wr_en, wr_addr, win_valid, win_addr, win_row, win_col,
               busy, done, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/conv_frame_ctrl.sv
// ============================================================================
//  Module   : conv_frame_ctrl
//  Purpose  : Frame controller - buffers one IMG_W x IMG_H frame and issues
//             every KxK window as soon as its last pixel has been written.
//  Option   : CONV_FRAME_CTRL_PERF_EN enables the datapath starvation counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_frame_ctrl #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int K       = 3,
    parameter int ADDR_W  = 11,
    parameter int COORD_W = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    conv_frame_ctrl_if.master  bus
);

    localparam int C_N        = IMG_W * IMG_H;
    localparam int C_COL_LAST = IMG_W - K;
    localparam int C_ROW_LAST = IMG_H - K;
    localparam int C_NEED_OFS = (K - 1) * IMG_W + (K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W:0]    r_pix_cnt;
    logic [ADDR_W-1:0]  r_win_addr;
    logic [COORD_W-1:0] r_win_row;
    logic [COORD_W-1:0] r_win_col;

    logic [ADDR_W+1:0]  w_need;
    logic               w_pix_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_win_valid;
    logic               w_pix_hs;
    logic               w_win_hs;
    logic               w_start_acc;
    logic               w_last_pix;
    logic               w_col_wrap;
    logic               w_last_win;

    // Window is ready once its bottom-right pixel index lies below the written count.
    assign w_need      = {2'b00, r_win_addr} + (ADDR_W+2)'(C_NEED_OFS);
    assign w_win_valid = w_busy && ({1'b0, r_pix_cnt} > w_need);

    assign w_pix_hs    = w_pix_ready & bus.pix_valid;
    assign w_win_hs    = w_win_valid & bus.win_ready;
    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_last_pix  = (r_pix_cnt == (ADDR_W+1)'(C_N - 1));
    assign w_col_wrap  = (r_win_col == COORD_W'(C_COL_LAST));
    assign w_last_win  = w_col_wrap && (r_win_row == COORD_W'(C_ROW_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pix_ready = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_pix_ready = 1'b1;
                w_busy      = 1'b1;
                if (w_pix_hs && w_last_pix) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_win_hs && w_last_win) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_cnt  <= '0;
            r_win_addr <= '0;
            r_win_row  <= '0;
            r_win_col  <= '0;
        end else if (w_start_acc) begin
            r_pix_cnt  <= '0;
            r_win_addr <= '0;
            r_win_row  <= '0;
            r_win_col  <= '0;
        end else begin
            if (w_pix_hs) begin
                r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
            end
            if (w_win_hs) begin
                if (w_col_wrap) begin
                    // Skip the K-1 columns that cannot start a window.
                    r_win_col  <= '0;
                    r_win_row  <= r_win_row + COORD_W'(1);
                    r_win_addr <= r_win_addr + ADDR_W'(K);
                end else begin
                    r_win_col  <= r_win_col + COORD_W'(1);
                    r_win_addr <= r_win_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef CONV_FRAME_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_busy && bus.win_ready && !w_win_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 16'd0;
`endif

    assign bus.pix_ready = w_pix_ready;
    assign bus.wr_en     = w_pix_hs;
    assign bus.wr_addr   = r_pix_cnt[ADDR_W-1:0];
    assign bus.win_valid = w_win_valid;
    assign bus.win_addr  = r_win_addr;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: random stimulus against a frame-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_frame_ctrl;

    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int K       = 3;
    localparam int ADDR_W  = 11;
    localparam int COORD_W = 6;
    localparam int N       = IMG_W * IMG_H;
    localparam int NWX     = IMG_W - K + 1;
    localparam int NWY     = IMG_H - K + 1;
    localparam int NW      = NWX * NWY;

    typedef struct {
        int row;
        int col;
        int addr;
    } win_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    conv_frame_ctrl_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus ();

    conv_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    win_t exp_win[$];
    int   exp_wr[$];

    // Reference model: 0 idle, 1 frame active, 2 completion pulse
    int   m_phase = 0;
    int   m_pix   = 0;
    int   m_widx  = 0;
    int   m_stall = 0;
    bit   e_ready;
    bit   e_wv;

    int   win_hs_cnt      = 0;
    int   done_cnt        = 0;
    int   dut_wr_cnt      = 0;
    int   first_win_wr    = -1;
    int   first_win_stall = -1;
    int   last_row = -1, last_col = -1, last_addr = -1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the highest pixel a window covers, from its raster coordinates.
    function automatic int need_of(input int idx);
        int row, col;
        row = idx / NWX;
        col = idx % NWX;
        return (row + K - 1) * IMG_W + (col + K - 1);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_pix   = 0;
            m_widx  = 0;
            m_stall = 0;
        end else begin
            e_ready = (m_phase == 1) && (m_pix < N);
            e_wv    = (m_phase == 1) && (m_widx < NW) && (m_pix > need_of(m_widx));
            check("pix_ready", int'(bus.pix_ready), int'(e_ready));
            check("wr_en", int'(bus.wr_en), int'(e_ready && bus.pix_valid));
            check("win_valid", int'(bus.win_valid), int'(e_wv));
            check("busy", int'(bus.busy), int'(m_phase == 1));
            check("done", int'(bus.done), int'(m_phase == 2));
`ifdef CONV_FRAME_CTRL_PERF_EN
            check("stall_cnt", int'(bus.stall_cnt), m_stall);
`else
            check("stall_cnt", int'(bus.stall_cnt), 0);
`endif
            if (bus.win_valid && bus.win_ready) begin
                if (win_hs_cnt == 0) begin
                    first_win_wr    = dut_wr_cnt;
                    first_win_stall = int'(bus.stall_cnt);
                end
                win_hs_cnt++;
                last_row  = int'(bus.win_row);
                last_col  = int'(bus.win_col);
                last_addr = int'(bus.win_addr);
                if (exp_win.size() == 0) begin
                    check("win_unexpected", 1, 0);
                end else begin
                    win_t w;
                    w = exp_win.pop_front();
                    check("win_row", int'(bus.win_row), w.row);
                    check("win_col", int'(bus.win_col), w.col);
                    check("win_addr", int'(bus.win_addr), w.addr);
                end
            end
            if (bus.wr_en) begin
                dut_wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    check("wr_addr", int'(bus.wr_addr), exp_wr.pop_front());
                end
            end
            if (bus.done) done_cnt++;

            case (m_phase)
                0: begin
                    if (bus.start) begin
                        m_phase = 1;
                        m_pix   = 0;
                        m_widx  = 0;
                        m_stall = 0;
                        win_hs_cnt = 0;
                        done_cnt   = 0;
                        dut_wr_cnt = 0;
                        exp_wr.delete();
                        exp_win.delete();
                        for (int i = 0; i < N; i++) exp_wr.push_back(i);
                        for (int r = 0; r < NWY; r++)
                            for (int c = 0; c < NWX; c++)
                                exp_win.push_back('{r, c, r * IMG_W + c});
                    end
                end
                1: begin
                    if (bus.win_ready && !e_wv && m_stall < 65535) m_stall++;
                    if (e_ready && bus.pix_valid) m_pix++;
                    if (e_wv && bus.win_ready) begin
                        m_widx++;
                        if (m_widx == NW) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic drive_cycle(input int pv_pct, input int wr_pct, input int st_pct);
        if (pv_pct < 0) bus.pix_valid = ~bus.pix_valid;
        else            bus.pix_valid = ($urandom_range(99) < pv_pct);
        bus.win_ready = ($urandom_range(99) < wr_pct);
        bus.start     = ($urandom_range(99) < st_pct);
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input int pv_pct, input int wr_pct);
        bus.start     = 1'b1;
        bus.pix_valid = (pv_pct < 0) ? 1'b1 : ($urandom_range(99) < pv_pct);
        bus.win_ready = ($urandom_range(99) < wr_pct);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_to_done(input int pv_pct, input int wr_pct, input int st_pct, input int budget);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            drive_cycle(pv_pct, wr_pct, st_pct);
            cyc++;
        end
        bus.start = 1'b0;
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: no done after %0d cycles, expected done", budget);
        end
        repeat (3) @(posedge clk);
        #1;
        check("busy_after_done", int'(bus.busy), 0);
        check("done_pulses", done_cnt, 1);
        check("window_count", win_hs_cnt, NW);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Pixels offered without start must be refused
        repeat (20) drive_cycle(100, 100, 0);
        check("idle_wr_count", dut_wr_cnt, 0);

        // Continuous streaming frame
        start_frame(100, 100);
        run_to_done(100, 100, 0, 3000);
        check("first_win_after_pixels", first_win_wr, 67);
        check("last_win_row", last_row, IMG_H - K);
        check("last_win_col", last_col, IMG_W - K);
        check("last_win_addr", last_addr, (IMG_H - K) * IMG_W + IMG_W - K);
        check("frame_writes", dut_wr_cnt, N);
`ifdef CONV_FRAME_CTRL_PERF_EN
        check("stall_at_first_win", first_win_stall, 67);
`else
        check("stall_at_first_win", first_win_stall, 0);
`endif

        // Windows blocked during the whole ingest
        start_frame(100, 0);
        repeat (N + 4) drive_cycle(100, 0, 0);
        check("drain_writes", dut_wr_cnt, N);
        check("drain_win_valid", int'(bus.win_valid), 1);
        check("drain_win_addr", int'(bus.win_addr), 0);
        check("drain_pix_ready", int'(bus.pix_ready), 0);
        check("drain_busy", int'(bus.busy), 1);
        run_to_done(100, 100, 0, NW + 4);

        // Toggling pix_valid with stray start pulses
        start_frame(-1, 100);
        run_to_done(-1, 100, 10, 4000);
        check("toggle_writes", dut_wr_cnt, N);

        // Random frames
        start_frame(50, 70);
        run_to_done(50, 70, 5, 8000);
        start_frame(80, 30);
        run_to_done(80, 30, 3, 8000);

        // Asynchronous reset in the middle of a frame
        start_frame(100, 100);
        repeat (150) drive_cycle(100, 100, 0);
        check("busy_before_reset", int'(bus.busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_pix_ready", int'(bus.pix_ready), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_win_valid", int'(bus.win_valid), 0);
        check("rst_win_addr", int'(bus.win_addr), 0);
        check("rst_win_row", int'(bus.win_row), 0);
        check("rst_win_col", int'(bus.win_col), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_stall_cnt", int'(bus.stall_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dut_wr_cnt = 0;
        repeat (20) drive_cycle(100, 100, 0);
        check("post_reset_wr_count", dut_wr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
